// File: rtl/wb_cmd_master_pkg.sv
// Shared types and default sizing for the Wishbone command master.
package wb_master_pkg;

    localparam int unsigned DEF_AW      = 32;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned DEF_CW      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                    we;
        logic [DEF_AW-1:0]       adr;
        logic [DEF_DW-1:0]       dat;
        logic [DEF_DW/8-1:0]     sel;
    } cmd_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus bundle between the command master and a slave.
interface wb_cmd_master_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    localparam int unsigned SW = DW / 8;

    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_ack_i;
    logic [DW-1:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wb_cmd_master_timeout_ctr.sv
// Counts bus cycles without ack; expire fires when strobe has been high TIMEOUT cycles.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expire = 1'b0;
        end else begin : g_timeout
            assign expire = (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: one bus cycle per command, response with timeout abort.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned SW      = DW / 8,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_dat,
    input  logic [SW-1:0] cmd_sel,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_err,
    wb_cmd_master_if.master wbm,
    output logic          stray_ack_o
);
    state_e        state_q,     state_d;
    logic          cyc_q,       cyc_d;
    logic          we_q,        we_d;
    logic [SW-1:0] sel_q,       sel_d;
    logic [AW-1:0] adr_q,       adr_d;
    logic [DW-1:0] dat_q,       dat_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_dat_q,   rsp_dat_d;
    logic          rsp_err_q,   rsp_err_d;
    logic          stray_q,     stray_d;
    logic          ctr_clr;
    logic          ctr_en;
    logic          expire;

    assign cmd_ready = (state_q == IDLE) && !wb_rst_i;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout_ctr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (ctr_clr),
        .en     (ctr_en),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        ctr_clr     = (state_q != BUS);
        ctr_en      = 1'b0;
        // Ack outside a live cycle is only recorded, never acted on.
        stray_d     = stray_q | (wbm.wbm_ack_i && (state_q != BUS));

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    sel_d   = cmd_sel;
                    dat_d   = cmd_we ? cmd_dat : '0;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (wbm.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : wbm.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (expire) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            stray_q     <= stray_d;
        end
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_dat       = rsp_dat_q;
    assign rsp_err       = rsp_err_q;
    assign stray_ack_o   = stray_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master with a scripted Wishbone slave and TIMEOUT=4.
module tb_wb_cmd_master;
    import wb_master_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    typedef struct {
        cmd_t        cmd;
        int          d;
        logic [31:0] rdata;
    } slv_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          stb_cycles;
        longint      acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          stray_ack;
    logic          s_ack = 1'b0;
    logic          force_ack = 1'b0;
    logic [DW-1:0] s_dat = '0;
    int            ready_mode = 0;
    int            last_stb = 0;
    longint        cycle = 0;
    int            total = 0;
    int            bad = 0;
    slv_t          slv_q[$];
    exp_t          exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    wb_cmd_master_if #(.AW(AW), .DW(DW)) wbm ();
    assign wbm.wbm_ack_i = s_ack | force_ack;
    assign wbm.wbm_dat_i = s_dat;

    wb_cmd_master #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO), .CW(3)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .wbm         (wbm),
        .stray_ack_o (stray_ack)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Reference: slave acks on stb cycle index d; no ack by cycle TO-1 means abort.
    function automatic exp_t model(input cmd_t c, input int d, input logic [31:0] rd);
        exp_t e;
        if (d < TO) begin
            e.err = 1'b0;
            e.dat = c.we ? 32'h0 : rd;
            e.stb_cycles = d + 1;
        end else begin
            e.err = 1'b1;
            e.dat = 32'h0;
            e.stb_cycles = TO;
        end
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input cmd_t c, input int d, input logic [31:0] rd, input bit want);
        int w;
        exp_t e;
        slv_t s;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_we = c.we; cmd_adr = c.adr; cmd_dat = c.dat; cmd_sel = c.sel;
        w = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            w++;
            if (w > 200) begin
                fail_now("cmd_accept_timeout");
                cmd_valid = 1'b0;
                return;
            end
        end
        s.cmd = c; s.d = d; s.rdata = rd;
        slv_q.push_back(s);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        if (want) begin
            e = model(c, d, rd);
            e.acc = cycle;
            exp_q.push_back(e);
        end
        check("issue_latency", {wbm.wbm_cyc_o, wbm.wbm_stb_o}, 2'b11);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
    endtask

    // Scripted slave: acks on stb cycle index d, checks bus fields every stb cycle.
    initial begin : slave
        slv_t cur;
        bit active = 0;
        int n = 0;
        forever begin
            @(posedge clk); #1;
            if (wbm.wbm_cyc_o && wbm.wbm_stb_o) begin
                if (!active) begin
                    if (slv_q.size() == 0) begin
                        fail_now("unexpected_bus_cycle");
                        cur.cmd = '0; cur.d = 100; cur.rdata = 0;
                    end else begin
                        cur = slv_q.pop_front();
                    end
                    active = 1; n = 0;
                end
                check("bus_fields",
                      {wbm.wbm_adr_o, wbm.wbm_dat_o, wbm.wbm_sel_o, wbm.wbm_we_o},
                      {cur.cmd.adr, (cur.cmd.we ? cur.cmd.dat : 32'h0), cur.cmd.sel, cur.cmd.we});
                s_ack = (n == cur.d);
                s_dat = (n == cur.d) ? cur.rdata : $urandom;
                n++;
            end else begin
                if (active) last_stb = n;
                active = 0;
                s_ack = 1'b0;
                s_dat = $urandom;
            end
        end
    end

    initial begin : ready_drv
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        bit          pv = 0, pr = 0;
        logic [31:0] pd = 0;
        logic        pe = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
                continue;
            end
            if (!wbm.wbm_cyc_o) check("idle_stb_we", {wbm.wbm_stb_o, wbm.wbm_we_o}, 2'b00);
            if (rsp_valid) begin
                check("no_accept_in_resp", cmd_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = exp_q[0];
                    if (!pv) begin
                        check("rsp_latency", 64'(cycle - e.acc), 64'(e.stb_cycles));
                        check("stb_cycles", last_stb, e.stb_cycles);
                    end else if (!pr) begin
                        check("rsp_stable", {rsp_dat, rsp_err}, {pd, pe});
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        check("rsp_dat", rsp_dat, e.dat);
                        check("rsp_err", rsp_err, e.err);
                    end
                end
            end
            pv = rsp_valid; pr = rsp_ready; pd = rsp_dat; pe = rsp_err;
        end
    end

    initial begin : main
        cmd_t c;
        int   w;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              {wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o, wbm.wbm_sel_o, wbm.wbm_adr_o,
               wbm.wbm_dat_o, rsp_valid, rsp_dat, rsp_err, stray_ack, cmd_ready}, 128'h0);
        rst = 1'b0;

        c = '{we: 1'b1, adr: 32'h3000_0004, dat: 32'hDEAD_BEEF, sel: 4'hF};
        issue(c, 2, $urandom, 1);
        c = '{we: 1'b0, adr: 32'h3000_0010, dat: $urandom, sel: 4'hF};
        issue(c, 0, 32'h1234_5678, 1);
        c = '{we: 1'b0, adr: 32'h3000_0020, dat: $urandom, sel: 4'h3};
        issue(c, 9, $urandom, 1);
        c = '{we: 1'b0, adr: 32'h3000_0024, dat: $urandom, sel: 4'hC};
        issue(c, 3, 32'hCAFE_F00D, 1);
        drain();

        ready_mode = 2;
        c = '{we: 1'b0, adr: 32'h3000_0040, dat: $urandom, sel: 4'hF};
        issue(c, 0, 32'hA5A5_0F0F, 1);
        w = 0;
        while (!rsp_valid && w < 20) begin @(posedge clk); #1; w++; end
        repeat (5) @(posedge clk);
        #1;
        check("backpressure_hold", {rsp_valid, cmd_ready}, 2'b10);
        ready_mode = 0;
        c = '{we: 1'b1, adr: 32'h3000_0044, dat: 32'h0BAD_F00D, sel: 4'h5};
        issue(c, 1, $urandom, 1);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            c.we = 1'($urandom); c.adr = $urandom; c.dat = $urandom; c.sel = 4'($urandom);
            issue(c, $urandom_range(0, 6), $urandom, 1);
        end
        drain();
        ready_mode = 0;

        c = '{we: 1'b1, adr: 32'h3000_0080, dat: 32'h1111_2222, sel: 4'hF};
        issue(c, 20, $urandom, 0);
        @(posedge clk); #1;
        check("mid_reset_in_bus", wbm.wbm_cyc_o, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_drop", {wbm.wbm_cyc_o, wbm.wbm_stb_o, rsp_valid, cmd_ready}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_idle", cmd_ready, 1'b1);
        repeat (6) @(posedge clk);
        check("mid_reset_no_rsp", exp_q.size(), 0);

        check("stray_clear", stray_ack, 1'b0);
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        check("stray_set", stray_ack, 1'b1);
        c = '{we: 1'b0, adr: 32'h3000_0100, dat: $urandom, sel: 4'hF};
        issue(c, 1, 32'h7777_8888, 1);
        drain();
        check("stray_sticky", stray_ack, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("stray_reset", stray_ack, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic master. It is the initiator counterpart to the Wishbone slave port our user project exposes.
- It accepts single read/write commands on a valid/ready command channel and issues one Wishbone cycle per command.
- It returns read data, or an error, on a valid/ready response channel.
- It drives internal peripherals or the accelerator slave during bring-up and self-test, and includes a timeout so a missing ack never hangs the fabric.

Parameters:
- AW, 32, address width
- DW, 32, data width (must be a multiple of 8)
- SW, DW/8, byte-select width
- TIMEOUT, 255, bus cycles to wait for ack before aborting; 0 disables the timeout
- CW, 8, timeout counter width (must satisfy 2^CW > TIMEOUT)

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  AW  byte address
- cmd_dat  in  DW  write data
- cmd_sel  in  SW  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_dat  out  DW  read data (0 for writes and errors)
- rsp_err  out  1  1=timeout abort
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  SW  byte selects
- wbm_adr_o  out  AW  address
- wbm_dat_o  out  DW  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  DW  slave read data
- stray_ack_o  out  1  sticky flag: ack seen outside an active cycle

Behaviour:
- Reset: sampled on a wb_clk_i edge while wb_rst_i=1.
  - Next state is IDLE.
  - All registered outputs clear to 0: cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_dat, rsp_err, stray_ack_o; timeout counter cleared.
  - cmd_ready=0 while wb_rst_i=1.
  - Reset mid-cycle: cyc/stb fall on the next edge; any pending response is discarded with no rsp_valid.
- States IDLE, BUS, RESP, encoded as a 2-bit enum.
- IDLE:
  - cmd_ready=1, combinational from the state.
  - On cmd_valid&cmd_ready, latch we/adr/sel; latch dat only if we=1, otherwise dat_o=0.
  - Next state BUS. cyc=stb=1 from the cycle after the handshake (1-cycle issue latency).
- BUS:
  - cyc, stb, we, sel, adr and dat_o held stable; cmd_ready=0.
  - Counter increments each cycle without ack.
  - On wbm_ack_i=1: cyc/stb drop on the next edge; rsp_dat captures wbm_dat_i for reads, 0 for writes; rsp_err=0; next state RESP.
  - Timeout (TIMEOUT≠0, no ack): triggers on the cycle where the counter equals TIMEOUT-1, i.e. stb has been high for TIMEOUT cycles. cyc/stb drop, rsp_err=1, rsp_dat=0, next state RESP.
  - Ack and timeout in the same cycle: ack wins (rsp_err=0).
- RESP:
  - rsp_valid=1, and rsp_dat/rsp_err are held stable until rsp_ready=1.
  - On the handshake: rsp_valid=0 on the next edge and next state IDLE.
  - No command is accepted in the same cycle as the response handshake.
  - Minimum 3 cycles per transaction.
- Stray ack: wbm_ack_i=1 while in IDLE or RESP sets stray_ack_o, which stays set until reset and otherwise has no effect.
- The bus idles at adr/dat_o/sel of the last command. we returns to 0 when cyc drops.

Decomposition:
- Package wb_master_pkg holds:
  - state enum {IDLE, BUS, RESP}
  - default AW/DW/TIMEOUT constants
  - a command struct (we, adr, dat, sel)
- Sub-module wb_timeout_ctr: CW-bit counter with clear/enable inputs and an expire output (expire tied to 0 when TIMEOUT=0).
- Top level holds the FSM and the latches.

Test Plan:
- Write: cmd{we=1, adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF}, slave acks 2 cycles after stb.
  - cyc/stb high 1 cycle after the handshake, adr/dat stable throughout.
  - rsp_valid with rsp_err=0 and rsp_dat=0.
- Read: cmd{we=0, adr=0x3000_0010}, slave returns 0x1234_5678 with ack on the first stb cycle.
  - wbm_dat_o=0 during the cycle.
  - rsp_dat=0x12345678, rsp_err=0; 3-cycle total when rsp_ready is tied high.
- Timeout with TIMEOUT=4 and no ack.
  - stb high exactly 4 cycles, then dropped.
  - rsp_err=1, rsp_dat=0.
- Timeout with TIMEOUT=4, ack on the 4th stb cycle.
  - rsp_err=0 and read data captured.
- Backpressure: rsp_ready=0 for 5 cycles after a read.
  - rsp_valid/rsp_dat stable, cmd_ready=0.
  - A new cmd_valid is not accepted until the cycle after rsp_ready=1.
- Edge cases:
  - wb_rst_i asserted on the 2nd BUS cycle: cyc/stb/rsp_valid=0 on the next edge, state IDLE.
  - Ack pulsed in IDLE: stray_ack_o=1 and stays set until reset.
